// File: rtl/yarvi_reg_scoreboard_pkg.sv
// Shared constants and types for the YARVI integer register scoreboard.
// Holds the register-index width, register count and a one-hot helper.
package yarvi_reg_scoreboard_pkg;

   localparam int REG_IDX_W = 5;
   localparam int REG_CNT   = 32;

   typedef logic [REG_IDX_W-1:0] reg_idx_t;
   typedef logic [REG_CNT-1:0]   reg_map_t;

   // One-hot bitmap with only the bit for register idx set.
   function automatic reg_map_t reg_bit(input reg_idx_t idx);
      reg_bit = reg_map_t'(1) << idx;
   endfunction

endpackage

// File: rtl/yarvi_reg_scoreboard.sv
// YARVI integer register scoreboard: tracks registers with an issued but not
// yet written-back write, and stalls issue on RAW/WAW hazards or when the
// outstanding-write budget is exhausted.
// Optional feature macro: YARVI_SB_WB_BYPASS_EN -- a register writing back
// this cycle is treated as already free for hazard checks (needs a
// write-through register file).
module yarvi_reg_scoreboard
   import yarvi_reg_scoreboard_pkg::*;
#(
   parameter int  MAX_OUTSTANDING = 4,
   localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             issue_valid,
   input  logic             issue_use_rs1,
   input  logic             issue_use_rs2,
   input  reg_idx_t         issue_rs1,
   input  reg_idx_t         issue_rs2,
   input  logic             issue_use_rd,
   input  reg_idx_t         issue_rd,
   output logic             issue_ready,
   input  logic             wb_valid,
   input  reg_idx_t         wb_rd,
   input  logic             flush,
   output reg_map_t         pending,
   output logic [CNT_W-1:0] outstanding,
   output logic             wb_err
);

   reg_map_t         pending_q, pending_d;
   logic [CNT_W-1:0] outstanding_q, outstanding_d;
   logic             wb_err_q, wb_err_d;

   reg_map_t pend_chk;
   logic     rd_eff, wb_nz, raw, waw, full, fire, wb_hit, wb_miss;

   // Hazard detection, issue handshake and next-state computation.
   always_comb begin
      rd_eff = issue_use_rd && (issue_rd != '0);
      wb_nz  = wb_valid && (wb_rd != '0);

      pend_chk = pending_q;
`ifdef YARVI_SB_WB_BYPASS_EN
      if (wb_nz) pend_chk = pending_q & ~reg_bit(wb_rd);
`endif

      raw  = (issue_use_rs1 && pend_chk[issue_rs1]) ||
             (issue_use_rs2 && pend_chk[issue_rs2]);
      waw  = rd_eff && pend_chk[issue_rd];
      full = rd_eff && (outstanding_q == CNT_W'(MAX_OUTSTANDING));

      issue_ready = !(raw || waw || full) && !flush;
      fire        = issue_valid && issue_ready && rd_eff;

      wb_hit  = wb_nz &&  pending_q[wb_rd];
      wb_miss = wb_nz && !pending_q[wb_rd];

      pending_d     = pending_q;
      outstanding_d = outstanding_q;
      wb_err_d      = wb_err_q;

      if (flush) begin
         // Flush wins over everything; a same-cycle writeback is dropped.
         pending_d     = '0;
         outstanding_d = '0;
      end else begin
         // Clear before set so a bypassed same-register re-issue stays pending.
         if (wb_hit) pending_d = pending_d & ~reg_bit(wb_rd);
         if (fire)   pending_d = pending_d |  reg_bit(issue_rd);
         outstanding_d = outstanding_q + CNT_W'(fire) - CNT_W'(wb_hit);
         wb_err_d      = wb_err_q | wb_miss;
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pending_q     <= '0;
         outstanding_q <= '0;
         wb_err_q      <= 1'b0;
      end else begin
         pending_q     <= pending_d;
         outstanding_q <= outstanding_d;
         wb_err_q      <= wb_err_d;
      end
   end

   assign pending     = pending_q;
   assign outstanding = outstanding_q;
   assign wb_err      = wb_err_q;

`ifndef SYNTHESIS
   // The incremental counter must always equal the bitmap population.
   a_count_matches: assert property (@(posedge clock) disable iff (reset)
      int'(outstanding_q) == $countones(pending_q));
`endif

endmodule
